// File: rtl/fetch_queue.sv
// Instruction fetch queue between the fetch and decode stages.
// Carries {pc, instr, misalign} entries in order, with flush on redirect and a sticky overflow flag.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_valid,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instr,
    output logic            push_ready,
    output logic            pop_valid,
    output logic [XLEN-1:0] pop_pc,
    output logic [XLEN-1:0] pop_instr,
    output logic            pop_misalign,
    input  logic            pop_ready,
    input  logic            flush,
    output logic [$clog2(DEPTH):0] count,
    output logic            overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_instr [DEPTH];
    logic            mem_mis   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_fire;
    logic          pop_fire;

    // Handshake status depends only on the registered count, so neither
    // push_ready nor pop_valid can form a combinational loop with the neighbours.
    assign push_ready = (count != FULL_COUNT);
    assign pop_valid  = (count != '0);

    assign push_fire = push_valid && push_ready && !flush;
    assign pop_fire  = pop_valid && pop_ready && !flush;

    assign pop_pc       = pop_valid ? mem_pc[rd_ptr]    : '0;
    assign pop_instr    = pop_valid ? mem_instr[rd_ptr] : '0;
    assign pop_misalign = pop_valid ? mem_mis[rd_ptr]   : 1'b0;

    // NOTE: storage is cleared on reset so the queue powers up fully defined;
    // flush only rewinds pointers because stale entries are masked at the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
                mem_mis[i]   <= 1'b0;
            end
        end else if (push_fire) begin
            mem_pc[wr_ptr]    <= push_pc;
            mem_instr[wr_ptr] <= push_instr;
            mem_mis[wr_ptr]   <= (push_pc[1:0] != 2'b00);
        end
    end

    // NOTE: non-blocking assignments keep every register update tied to the
    // same edge, independent of statement order inside the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PW'(1);
            if (pop_fire)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_valid && !push_ready) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=4, XLEN=32).
// Each vector drives one cycle of inputs and checks the outputs after the edge.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid;
    logic [31:0] push_pc;
    logic [31:0] push_instr;
    logic        push_ready;
    logic        pop_valid;
    logic [31:0] pop_pc;
    logic [31:0] pop_instr;
    logic        pop_misalign;
    logic        pop_ready;
    logic        flush;
    logic [2:0]  count;
    logic        overflow_err;

    int n_compared = 0;
    int n_failed   = 0;

    fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .push_valid   (push_valid),
        .push_pc      (push_pc),
        .push_instr   (push_instr),
        .push_ready   (push_ready),
        .pop_valid    (pop_valid),
        .pop_pc       (pop_pc),
        .pop_instr    (pop_instr),
        .pop_misalign (pop_misalign),
        .pop_ready    (pop_ready),
        .flush        (flush),
        .count        (count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        pv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pr;
        logic        e_prdy;
        logic        e_pv;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic        e_mis;
        logic [2:0]  e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t va[$];
    vec_t vb[$];

    // Expected state held since the previous edge; outputs must not move before the next edge.
    logic       prev_prdy;
    logic       prev_pv;
    logic [2:0] prev_cnt;

    function automatic vec_t mk(logic rst, logic fl, logic pv, logic [31:0] pc, logic [31:0] ins,
                                logic pr, logic e_prdy, logic e_pv, logic [31:0] e_pc,
                                logic [31:0] e_ins, logic e_mis, logic [2:0] e_cnt, logic e_ovf);
        vec_t v;
        v.rst = rst; v.fl = fl; v.pv = pv; v.pc = pc; v.ins = ins; v.pr = pr;
        v.e_prdy = e_prdy; v.e_pv = e_pv; v.e_pc = e_pc; v.e_ins = e_ins;
        v.e_mis = e_mis; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        reset = v.rst; flush = v.fl; push_valid = v.pv;
        push_pc = v.pc; push_instr = v.ins; pop_ready = v.pr;
        #1;
        // No bypass and no input-to-ready path: status still reflects the old state.
        check({tag, "_pre_prdy"}, 32'(push_ready), 32'(prev_prdy));
        check({tag, "_pre_pv"},   32'(pop_valid),  32'(prev_pv));
        check({tag, "_pre_cnt"},  32'(count),      32'(prev_cnt));
        @(posedge clk);
        #1;
        check({tag, "_prdy"}, 32'(push_ready),   32'(v.e_prdy));
        check({tag, "_pv"},   32'(pop_valid),    32'(v.e_pv));
        check({tag, "_pc"},   pop_pc,            v.e_pc);
        check({tag, "_ins"},  pop_instr,         v.e_ins);
        check({tag, "_mis"},  32'(pop_misalign), 32'(v.e_mis));
        check({tag, "_cnt"},  32'(count),        32'(v.e_cnt));
        check({tag, "_ovf"},  32'(overflow_err), 32'(v.e_ovf));
        prev_prdy = v.e_prdy; prev_pv = v.e_pv; prev_cnt = v.e_cnt;
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'h0000_0013;
    endfunction

    initial begin
        // Fill, overflow, pop-while-full, drain, pop-on-empty, flush clearing overflow.
        //          rst fl pv pc          ins            pr | prdy pv e_pc        e_ins          mis cnt ovf
        va.push_back(mk(1, 0, 0, 32'h0,    32'h0,         0,  1, 0, 32'h0,     32'h0,         0, 0, 0));
        va.push_back(mk(0, 0, 1, 32'h0,    32'h0000_0013, 0,  1, 1, 32'h0,     32'h0000_0013, 0, 1, 0));
        va.push_back(mk(0, 0, 1, 32'h4,    32'h0040_0093, 0,  1, 1, 32'h0,     32'h0000_0013, 0, 2, 0));
        va.push_back(mk(0, 0, 1, 32'h8,    32'h0080_0113, 0,  1, 1, 32'h0,     32'h0000_0013, 0, 3, 0));
        va.push_back(mk(0, 0, 1, 32'hC,    32'h00C0_0193, 0,  0, 1, 32'h0,     32'h0000_0013, 0, 4, 0));
        va.push_back(mk(0, 0, 1, 32'h10,   32'hDEAD_BEEF, 0,  0, 1, 32'h0,     32'h0000_0013, 0, 4, 1));
        va.push_back(mk(0, 0, 1, 32'h10,   32'hDEAD_BEEF, 1,  1, 1, 32'h4,     32'h0040_0093, 0, 3, 1));
        va.push_back(mk(0, 0, 0, 32'h0,    32'h0,         1,  1, 1, 32'h8,     32'h0080_0113, 0, 2, 1));
        va.push_back(mk(0, 0, 0, 32'h0,    32'h0,         1,  1, 1, 32'hC,     32'h00C0_0193, 0, 1, 1));
        va.push_back(mk(0, 0, 0, 32'h0,    32'h0,         1,  1, 0, 32'h0,     32'h0,         0, 0, 1));
        va.push_back(mk(0, 0, 0, 32'h0,    32'h0,         1,  1, 0, 32'h0,     32'h0,         0, 0, 1));
        va.push_back(mk(0, 1, 0, 32'h0,    32'h0,         0,  1, 0, 32'h0,     32'h0,         0, 0, 0));

        // Flush discarding a push, flush beating overflow, misalign flag, reset over a full queue.
        vb.push_back(mk(0, 0, 1, 32'h12C,  ins_of(32'h12C), 0, 1, 1, 32'h128, ins_of(32'h128), 0, 2, 0));
        vb.push_back(mk(0, 0, 1, 32'h130,  ins_of(32'h130), 0, 1, 1, 32'h128, ins_of(32'h128), 0, 3, 0));
        vb.push_back(mk(0, 1, 1, 32'h300,  32'h1111_1111,  1, 1, 0, 32'h0,   32'h0,          0, 0, 0));
        vb.push_back(mk(0, 0, 1, 32'h200,  32'h0000_0513,  0, 1, 1, 32'h200, 32'h0000_0513,  0, 1, 0));
        vb.push_back(mk(0, 0, 0, 32'h0,    32'h0,          1, 1, 0, 32'h0,   32'h0,          0, 0, 0));
        vb.push_back(mk(0, 0, 1, 32'h0,    32'h1,          0, 1, 1, 32'h0,   32'h1,          0, 1, 0));
        vb.push_back(mk(0, 0, 1, 32'h4,    32'h2,          0, 1, 1, 32'h0,   32'h1,          0, 2, 0));
        vb.push_back(mk(0, 0, 1, 32'h8,    32'h3,          0, 1, 1, 32'h0,   32'h1,          0, 3, 0));
        vb.push_back(mk(0, 0, 1, 32'hC,    32'h4,          0, 0, 1, 32'h0,   32'h1,          0, 4, 0));
        vb.push_back(mk(0, 1, 1, 32'h10,   32'h5,          0, 1, 0, 32'h0,   32'h0,          0, 0, 0));
        vb.push_back(mk(0, 0, 1, 32'h102,  32'h5,          0, 1, 1, 32'h102, 32'h5,          1, 1, 0));
        vb.push_back(mk(0, 0, 1, 32'h104,  32'h6,          0, 1, 1, 32'h102, 32'h5,          1, 2, 0));
        vb.push_back(mk(0, 0, 0, 32'h0,    32'h0,          1, 1, 1, 32'h104, 32'h6,          0, 1, 0));
        vb.push_back(mk(0, 0, 1, 32'h108,  32'h7,          0, 1, 1, 32'h104, 32'h6,          0, 2, 0));
        vb.push_back(mk(0, 0, 1, 32'h10C,  32'h8,          0, 1, 1, 32'h104, 32'h6,          0, 3, 0));
        vb.push_back(mk(0, 0, 1, 32'h110,  32'h9,          0, 0, 1, 32'h104, 32'h6,          0, 4, 0));
        vb.push_back(mk(0, 0, 1, 32'h114,  32'hA,          0, 0, 1, 32'h104, 32'h6,          0, 4, 1));
        vb.push_back(mk(1, 1, 1, 32'h118,  32'hB,          1, 1, 0, 32'h0,   32'h0,          0, 0, 0));

        reset = 1'b1; flush = 1'b0; push_valid = 1'b0;
        push_pc = '0; push_instr = '0; pop_ready = 1'b0;
        repeat (2) @(posedge clk);
        prev_prdy = 1'b1; prev_pv = 1'b0; prev_cnt = 3'd0;

        foreach (va[i]) run_vec(va[i], $sformatf("a%0d", i));

        // Streaming: one entry in flight, push and pop every cycle; pointers wrap twice.
        run_vec(mk(0, 0, 1, 32'h100, ins_of(32'h100), 0, 1, 1, 32'h100, ins_of(32'h100), 0, 1, 0), "s_first");
        for (int i = 0; i < 10; i++) begin
            logic [31:0] pc_in;
            logic [31:0] pc_head;
            pc_in   = 32'h104 + 32'(4 * i);
            pc_head = pc_in;
            run_vec(mk(0, 0, 1, pc_in, ins_of(pc_in), 1, 1, 1, pc_head, ins_of(pc_head), 0, 1, 0),
                    $sformatf("s%0d", i));
        end

        foreach (vb[i]) run_vec(vb[i], $sformatf("b%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
